uart_tx_buffered: RTL and testbench

- Byte-oriented UART transmitter. Emits RS232 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Bit timing matches the existing UART receiver, so both use the same `clock_bit` value.
- An internal FIFO lets the bus side queue bytes without waiting on line timing. Frames go out back-to-back while the FIFO holds data.
- Sits between the bus/register interface and the serial line pin, as the transmit counterpart of the UART receive path.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 73 +++++++
 rtl/uart_tx_buffered.sv | 139 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-level constants,
// common to the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read port. full/empty are registered
// and derived from an occupancy count of 0..fifo_depth.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int fifo_depth = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write,
  input  logic [DATA_BITS-1:0] writedata,
  input  logic                 read,
  output logic [DATA_BITS-1:0] readdata,
  output logic                 full,
  output logic                 empty
);

  localparam int             AW       = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(fifo_depth);

  logic [DATA_BITS-1:0] mem_q [fifo_depth];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 do_wr, do_rd;

  // Pointer/count bookkeeping; a write while full is dropped even if a read
  // happens in the same cycle. Pointers wrap naturally (depth is a power of two).
  always_comb begin
    do_wr    = write && !full_q;
    do_rd    = read && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_wr && !do_rd)      count_d = count_q + CNT_ONE;
    else if (!do_wr && do_rd) count_d = count_q - CNT_ONE;
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= writedata;
  end

  assign readdata = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: 8N1 frames, LSB first, fed from an internal FIFO.
// Frames leave back-to-back while bytes are queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int clock_bit  = 5208,
  parameter int fifo_depth = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic       full,
  output logic       empty,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] CNT_LAST = 16'(clock_bit - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 fifo_read;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 bit_end;

  uart_tx_fifo #(
    .fifo_depth(fifo_depth)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .write    (write),
    .writedata(writedata),
    .read     (fifo_read),
    .readdata (fifo_rdata),
    .full     (full),
    .empty    (empty)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic. tx_d is the line level for the cycle after the edge, so
  // tx is a registered output that only changes on bit-period boundaries.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_read = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = STOP_LEVEL;
        cnt_d = '0;
        idx_d = '0;
        if (!empty) begin
          shift_d   = fifo_rdata;
          fifo_read = 1'b1;
          state_d   = START;
          tx_d      = START_LEVEL;
        end
      end
      START: begin
        tx_d = START_LEVEL;
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        tx_d = shift_q[idx_q];
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            tx_d    = STOP_LEVEL;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        tx_d = STOP_LEVEL;
        if (bit_end) begin
          cnt_d = '0;
          idx_d = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            shift_d   = fifo_rdata;
            fifo_read = 1'b1;
            state_d   = START;
            tx_d      = START_LEVEL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_LEVEL;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers; reset truncates any frame and forces the line idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= STOP_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Frame byte holder; loaded once per frame and held stable until the next load.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with clock_bit=4, fifo_depth=4.
module tb_uart_tx_buffered;

  localparam int CB = 4;
  localparam int FD = 4;
  localparam int FRAME = 10 * CB;

  logic       clock;
  logic       reset;
  logic       write;
  logic [7:0] writedata;
  logic       full, empty, tx, busy, done;

  int checks;
  int errors;
  int done_cnt;
  int d0;
  logic [7:0] rx_byte;
  logic       rx_ok;
  logic [7:0] rx_got [4];
  logic [7:0] lb_exp [4];

  uart_tx_buffered #(
    .clock_bit (CB),
    .fifo_depth(FD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .write    (write),
    .writedata(writedata),
    .full     (full),
    .empty    (empty),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial done_cnt = 0;
  always @(negedge clock) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks one frame sample by sample, starting at sample index 'first'
  // (sample 0 is the first cycle of the start bit).
  task automatic check_frame(input logic [7:0] b, input int first, input string tag);
    int   bitn;
    logic exp_tx;
    for (int s = first; s < FRAME; s++) begin
      bitn = s / CB;
      if (bitn == 0)      exp_tx = 1'b0;
      else if (bitn <= 8) exp_tx = b[bitn-1];
      else                exp_tx = 1'b1;
      chk($sformatf("%s tx s%0d", tag, s), tx, exp_tx);
      chk($sformatf("%s done s%0d", tag, s), done, (s == FRAME - 1));
      chk($sformatf("%s busy s%0d", tag, s), busy, 1'b1);
      tick();
    end
  endtask

  // Line-side decoder: find a falling edge, sample mid-bit.
  task automatic uart_rx(output logic [7:0] b, output logic ok);
    logic prev;
    int   n;
    b    = 8'h00;
    ok   = 1'b0;
    prev = tx;
    tick();
    n = 0;
    while (!(prev == 1'b1 && tx == 1'b0) && n < 400) begin
      prev = tx;
      tick();
      n++;
    end
    if (n >= 400) return;
    repeat (CB / 2) tick();
    chk("rx start", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CB) tick();
      b[i] = tx;
    end
    repeat (CB) tick();
    chk("rx stop", tx, 1'b1);
    ok = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    write     = 1'b0;
    writedata = 8'h00;
    lb_exp    = '{8'h00, 8'h80, 8'h7E, 8'hFF};

    // Reset idle
    repeat (3) tick();
    chk("rst tx", tx, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst empty", empty, 1'b1);
    chk("rst full", full, 1'b0);
    reset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("idle tx", tx, 1'b1);
      chk("idle busy", busy, 1'b0);
      chk("idle done", done, 1'b0);
      chk("idle empty", empty, 1'b1);
      chk("idle full", full, 1'b0);
    end

    // Single byte 0xA5
    writedata = 8'hA5;
    write     = 1'b1;
    tick();
    write = 1'b0;
    chk("single empty after write", empty, 1'b0);
    chk("single tx before start", tx, 1'b1);
    chk("single busy before start", busy, 1'b0);
    tick();
    check_frame(8'hA5, 0, "single");
    chk("single busy after", busy, 1'b0);
    chk("single done after", done, 1'b0);
    chk("single tx after", tx, 1'b1);
    chk("single empty after", empty, 1'b1);
    repeat (5) tick();

    // Back-to-back 0x00, 0xFF, 0x3C
    writedata = 8'h00;
    write     = 1'b1;
    tick();
    chk("b2b empty e0", empty, 1'b0);
    writedata = 8'hFF;
    tick();
    chk("b2b0 tx s0", tx, 1'b0);
    chk("b2b0 done s0", done, 1'b0);
    writedata = 8'h3C;
    tick();
    write = 1'b0;
    check_frame(8'h00, 1, "b2b0");
    chk("b2b empty f2", empty, 1'b0);
    check_frame(8'hFF, 0, "b2b1");
    chk("b2b empty f3", empty, 1'b1);
    check_frame(8'h3C, 0, "b2b2");
    chk("b2b busy end", busy, 1'b0);
    chk("b2b tx end", tx, 1'b1);
    repeat (5) tick();

    // Overflow: 0x01..0x06 on consecutive cycles, 0x06 must be dropped
    for (int i = 0; i < 6; i++) begin
      writedata = 8'(i + 1);
      write     = 1'b1;
      tick();
      if (i >= 1) chk($sformatf("ovf tx w%0d", i), tx, (i <= 4) ? 1'b0 : 1'b1);
      if (i == 3) chk("ovf full w3", full, 1'b0);
      if (i >= 4) chk($sformatf("ovf full w%0d", i), full, 1'b1);
    end
    write = 1'b0;
    check_frame(8'h01, 4, "ovf1");
    chk("ovf full after deq", full, 1'b0);
    check_frame(8'h02, 0, "ovf2");
    check_frame(8'h03, 0, "ovf3");
    check_frame(8'h04, 0, "ovf4");
    check_frame(8'h05, 0, "ovf5");
    chk("ovf busy end", busy, 1'b0);
    chk("ovf empty end", empty, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("ovf no sixth frame", tx, 1'b1);
    end

    // Reset mid-frame during data bit 3 of 0x55 with two bytes queued
    writedata = 8'h55;
    write     = 1'b1;
    tick();
    writedata = 8'hAA;
    tick();
    writedata = 8'h33;
    tick();
    write = 1'b0;
    for (int s = 1; s < 17; s++) tick();
    chk("midrst tx bit3", tx, 1'b0);
    chk("midrst empty before", empty, 1'b0);
    chk("midrst busy before", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst tx", tx, 1'b1);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst empty", empty, 1'b1);
    chk("midrst full", full, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    d0 = done_cnt;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("postrst tx", tx, 1'b1);
      chk("postrst busy", busy, 1'b0);
      chk("postrst empty", empty, 1'b1);
    end
    chk("postrst done count", done_cnt - d0, 0);

    // Loopback through a line-side decoder
    d0 = done_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          uart_rx(rx_byte, rx_ok);
          chk($sformatf("lb frame found %0d", k), rx_ok, 1'b1);
          rx_got[k] = rx_byte;
        end
      end
      begin
        writedata = 8'h00;
        write     = 1'b1;
        tick();
        writedata = 8'h80;
        tick();
        writedata = 8'h7E;
        tick();
        writedata = 8'hFF;
        tick();
        write = 1'b0;
      end
    join
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lb byte %0d", k), rx_got[k], lb_exp[k]);
    end
    chk("lb done count", done_cnt - d0, 4);
    chk("lb empty end", empty, 1'b1);
    chk("lb busy end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
